// File: rtl/writer_184.sv
// writer_184 - serializing transmitter for the 184-bit SCLK/SDIO framed link.
//
// Latches a parallel word on an accepted start and shifts it out LSB-index
// first (data_in[0] first, data_in[183] last). The receiver samples SDIO on
// every SCLK rising edge while init_key_flag is low, so every frame carries
// exactly FRAME_BITS rising edges.
//
// Parameters:
//   CLK_DIV     system clocks per SCLK half-period (1..255)
//   FRAME_BITS  bits per frame; fixed at 184 to match the receiver
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   start          send request, honoured in IDLE and in the DONE cycle
//   repeat_req     (WRITER_184_REPEAT_EN only) restart with a fresh latch of
//                  data_in when high in the DONE cycle
//   data_in        word to send, index 0 transmitted first
//   busy           frame in flight
//   done           one-cycle pulse at frame completion
//   init_key_flag  frame enable, idle high, low for the whole frame
//   SCLK_out       serial clock, idle low
//   SDIO_out       serial data, only changes while SCLK is low
//
// Build option: define WRITER_184_REPEAT_EN to add the repeat_req input.

module writer_184 #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FRAME_BITS = 184
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
`ifdef WRITER_184_REPEAT_EN
  input  logic                  repeat_req,
`endif
  input  logic [0:FRAME_BITS-1] data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  init_key_flag,
  output logic                  SCLK_out,
  output logic                  SDIO_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] BIT_END = 8'(FRAME_BITS);

  state_t                state;
  logic [7:0]            phase;
  logic [7:0]            bit_cnt;
  logic [0:FRAME_BITS-1] shreg;
  logic                  accept;
  logic                  phase_last;

  // SDIO is the head of the shift register; the register is cleared whenever
  // the link is idle, which keeps SDIO low outside a frame.
  assign SDIO_out   = shreg[0];
  assign phase_last = (phase == PH_LAST);

  always_comb begin
    accept = 1'b0;
    if (state == S_IDLE) begin
      accept = start;
    end else if (state == S_DONE) begin
`ifdef WRITER_184_REPEAT_EN
      accept = start | repeat_req;
`else
      accept = start;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      phase         <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      init_key_flag <= 1'b1;
      SCLK_out      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE behaves exactly like IDLE for acceptance, giving a single
        // flag-high cycle between back-to-back frames.
        S_IDLE, S_DONE: begin
          phase    <= '0;
          bit_cnt  <= '0;
          SCLK_out <= 1'b0;
          if (accept) begin
            state         <= S_LEAD;
            shreg         <= data_in;
            busy          <= 1'b1;
            init_key_flag <= 1'b0;
          end else begin
            state         <= S_IDLE;
            shreg         <= '0;
            busy          <= 1'b0;
            init_key_flag <= 1'b1;
          end
        end

        S_LEAD: begin
          if (phase_last) begin
            state    <= S_HIGH;
            phase    <= '0;
            SCLK_out <= 1'b1;
          end else begin
            phase <= phase + 8'd1;
          end
        end

        // Falling edge: advance SDIO in the same cycle so it gets a full
        // half-period of setup before the next rise.
        S_HIGH: begin
          if (phase_last) begin
            state    <= S_LOW;
            phase    <= '0;
            SCLK_out <= 1'b0;
            shreg    <= {shreg[1:FRAME_BITS-1], 1'b0};
            bit_cnt  <= bit_cnt + 8'd1;
          end else begin
            phase <= phase + 8'd1;
          end
        end

        // bit_cnt reaching FRAME_BITS marks the final fall; this LOW period
        // then serves as the trailing hold before the flag rises.
        S_LOW: begin
          if (phase_last) begin
            phase <= '0;
            if (bit_cnt == BIT_END) begin
              state         <= S_DONE;
              busy          <= 1'b0;
              done          <= 1'b1;
              init_key_flag <= 1'b1;
              shreg         <= '0;
            end else begin
              state    <= S_HIGH;
              SCLK_out <= 1'b1;
            end
          end else begin
            phase <= phase + 8'd1;
          end
        end

        default: begin
          state         <= S_IDLE;
          phase         <= '0;
          bit_cnt       <= '0;
          shreg         <= '0;
          busy          <= 1'b0;
          init_key_flag <= 1'b1;
          SCLK_out      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writer_184.sv
// Directed bench for writer_184: three instances (CLK_DIV = 4, 1, 2) share
// clk/reset, each feeding a receiver model that samples SDIO on SCLK rises
// while the flag is low and latches the word when the flag returns high.

module tb_writer_184;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [2:0]   start_v;
  logic [0:183] data_s [3];
`ifdef WRITER_184_REPEAT_EN
  logic [2:0]   rep_v;
`endif
  wire  [2:0]   busy_v, done_v, flag_v, sclk_v, sdio_v;

  int total = 0;
  int bad   = 0;

  writer_184 #(.CLK_DIV(4)) u_d4 (
    .clk(clk), .reset(reset), .start(start_v[0]),
`ifdef WRITER_184_REPEAT_EN
    .repeat_req(rep_v[0]),
`endif
    .data_in(data_s[0]), .busy(busy_v[0]), .done(done_v[0]),
    .init_key_flag(flag_v[0]), .SCLK_out(sclk_v[0]), .SDIO_out(sdio_v[0])
  );

  writer_184 #(.CLK_DIV(1)) u_d1 (
    .clk(clk), .reset(reset), .start(start_v[1]),
`ifdef WRITER_184_REPEAT_EN
    .repeat_req(rep_v[1]),
`endif
    .data_in(data_s[1]), .busy(busy_v[1]), .done(done_v[1]),
    .init_key_flag(flag_v[1]), .SCLK_out(sclk_v[1]), .SDIO_out(sdio_v[1])
  );

  writer_184 #(.CLK_DIV(2)) u_d2 (
    .clk(clk), .reset(reset), .start(start_v[2]),
`ifdef WRITER_184_REPEAT_EN
    .repeat_req(rep_v[2]),
`endif
    .data_in(data_s[2]), .busy(busy_v[2]), .done(done_v[2]),
    .init_key_flag(flag_v[2]), .SCLK_out(sclk_v[2]), .SDIO_out(sdio_v[2])
  );

  // Receiver model
  int           rx_cnt      [3];
  logic [0:183] rx_word     [3];
  logic [0:183] rx_last     [3];
  int           rx_last_cnt [3];
  int           done_cnt    [3] = '{0, 0, 0};
  logic         sclk_prev   [3];
  logic         flag_prev   [3];

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (reset) begin
        rx_cnt[g]    <= 0;
        rx_word[g]   <= '0;
        sclk_prev[g] <= 1'b0;
        flag_prev[g] <= 1'b1;
      end else begin
        if (!flag_v[g] && sclk_v[g] && !sclk_prev[g]) begin
          if (rx_cnt[g] < 184) rx_word[g][rx_cnt[g]] <= sdio_v[g];
          rx_cnt[g] <= rx_cnt[g] + 1;
        end
        if (flag_v[g] && !flag_prev[g]) begin
          rx_last[g]     <= rx_word[g];
          rx_last_cnt[g] <= rx_cnt[g];
          rx_cnt[g]      <= 0;
          rx_word[g]     <= '0;
        end
        if (done_v[g]) done_cnt[g] <= done_cnt[g] + 1;
        sclk_prev[g] <= sclk_v[g];
        flag_prev[g] <= flag_v[g];
      end
    end
  end

  task automatic chk(input string tag, input logic [183:0] obs, input logic [183:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int g, input int limit, output int cyc);
    cyc = 0;
    while (done_v[g] !== 1'b1 && cyc < limit) begin
      step(1);
      cyc++;
    end
  endtask

  task automatic rnd(output logic [0:183] v);
    for (int i = 0; i < 184; i++) v[i] = 1'($urandom_range(0, 1));
  endtask

  logic [0:183] wa, wb, wc;
  int cyc;

  initial begin
    reset   = 1'b1;
    start_v = '0;
`ifdef WRITER_184_REPEAT_EN
    rep_v   = '0;
`endif
    for (int g = 0; g < 3; g++) data_s[g] = '0;
    step(3);
    chk("rst_busy", busy_v, 3'b000);
    chk("rst_done", done_v, 3'b000);
    chk("rst_flag", flag_v, 3'b111);
    chk("rst_sclk", sclk_v, 3'b000);
    chk("rst_sdio", sdio_v, 3'b000);
    reset = 1'b0;
    step(1);

    // Single one in bit 0, CLK_DIV=4: exact edge timing
    data_s[0]    = '0;
    data_s[0][0] = 1'b1;
    start_v[0]   = 1'b1;                 // cycle T
    step(1);                             // T+1
    start_v[0] = 1'b0;
    chk("t1_busy", busy_v[0], 1'b1);
    chk("t1_flag", flag_v[0], 1'b0);
    chk("t1_sdio", sdio_v[0], 1'b1);
    chk("t1_sclk", sclk_v[0], 1'b0);
    step(3);                             // T+4
    chk("t4_sclk", sclk_v[0], 1'b0);
    step(1);                             // T+5
    chk("t5_rise", sclk_v[0], 1'b1);
    chk("t5_sdio", sdio_v[0], 1'b1);
    step(4);                             // T+9
    chk("t9_fall", sclk_v[0], 1'b0);
    chk("t9_sdio", sdio_v[0], 1'b0);
    step(1459);                          // T+1468
    chk("t1468_sclk", sclk_v[0], 1'b0);
    step(1);                             // T+1469
    chk("last_rise", sclk_v[0], 1'b1);
    step(4);                             // T+1473
    chk("last_fall", sclk_v[0], 1'b0);
    step(3);                             // T+1476
    chk("t1476_done", done_v[0], 1'b0);
    chk("t1476_flag", flag_v[0], 1'b0);
    chk("t1476_busy", busy_v[0], 1'b1);
    step(1);                             // T+1477
    chk("t1477_done", done_v[0], 1'b1);
    chk("t1477_flag", flag_v[0], 1'b1);
    chk("t1477_busy", busy_v[0], 1'b0);
    chk("t1477_sdio", sdio_v[0], 1'b0);
    step(1);
    chk("t1478_done", done_v[0], 1'b0);
    chk("one_word", rx_last[0], 184'(1) << 183);
    chk("one_rises", rx_last_cnt[0], 184);
    chk("one_dcnt", done_cnt[0], 1);

    // Alternating pattern, CLK_DIV=1
    for (int i = 0; i < 184; i++) data_s[1][i] = (i % 2 == 0);
    wa = data_s[1];
    start_v[1] = 1'b1;
    step(1);
    start_v[1] = 1'b0;
    wait_done(1, 400, cyc);
    chk("alt_lat", cyc, 369);
    step(1);
    chk("alt_word", rx_last[1], wa);
    chk("alt_rises", rx_last_cnt[1], 184);
    chk("alt_dcnt", done_cnt[1], 1);

    // start pulsed mid-frame, data changed after acceptance
    rnd(wa);
    data_s[0]  = wa;
    start_v[0] = 1'b1;
    step(1);                             // T+1
    start_v[0] = 1'b0;
    step(99);                            // T+100
    start_v[0] = 1'b1;
    data_s[0]  = ~wa;
    step(1);                             // T+101
    start_v[0] = 1'b0;
    chk("ign_busy", busy_v[0], 1'b1);
    wait_done(0, 2000, cyc);
    chk("ign_lat", cyc, 1376);
    step(1);
    chk("ign_word", rx_last[0], wa);
    chk("ign_rises", rx_last_cnt[0], 184);
    chk("ign_idle", {busy_v[0], flag_v[0]}, 2'b01);
    step(20);
    chk("ign_dcnt", done_cnt[0], 2);

    // Reset mid-frame at rise 50, then a clean frame
    rnd(wb);
    data_s[0]  = wb;
    start_v[0] = 1'b1;
    step(1);
    start_v[0] = 1'b0;
    cyc = 0;
    while (rx_cnt[0] < 50 && cyc < 1000) begin
      step(1);
      cyc++;
    end
    chk("r50_reach", rx_cnt[0] >= 50, 1'b1);
    reset = 1'b1;
    step(1);
    chk("rm_flag", flag_v[0], 1'b1);
    chk("rm_sclk", sclk_v[0], 1'b0);
    chk("rm_busy", busy_v[0], 1'b0);
    chk("rm_sdio", sdio_v[0], 1'b0);
    reset = 1'b0;
    step(1);
    rnd(wc);
    data_s[0]  = wc;
    start_v[0] = 1'b1;
    step(1);
    start_v[0] = 1'b0;
    wait_done(0, 2000, cyc);
    chk("rf_lat", cyc, 1476);
    step(1);
    chk("rf_word", rx_last[0], wc);
    chk("rf_rises", rx_last_cnt[0], 184);
    chk("rf_dcnt", done_cnt[0], 3);

    // start held high, CLK_DIV=2: back-to-back with a 1-cycle flag gap
    rnd(wa);
    rnd(wb);
    data_s[2]  = wa;
    start_v[2] = 1'b1;
    step(1);                             // T+1
    data_s[2]  = wb;
    chk("bb_flag0", flag_v[2], 1'b0);
    wait_done(2, 1000, cyc);
    chk("bb_lat1", cyc, 738);
    chk("bb_gap", {flag_v[2], busy_v[2]}, 2'b10);
    step(1);
    chk("bb_reopen", {flag_v[2], busy_v[2], done_v[2]}, 3'b010);
    chk("bb_word1", rx_last[2], wa);
    start_v[2] = 1'b0;
    wait_done(2, 1000, cyc);
    chk("bb_lat2", cyc, 738);
    step(1);
    chk("bb_word2", rx_last[2], wb);
    chk("bb_rises2", rx_last_cnt[2], 184);
    chk("bb_dcnt", done_cnt[2], 2);

`ifdef WRITER_184_REPEAT_EN
    // repeat: second frame re-latches the updated data_in
    rnd(wa);
    data_s[1]  = wa;
    rep_v[1]   = 1'b1;
    start_v[1] = 1'b1;
    step(1);
    start_v[1] = 1'b0;
    data_s[1]  = '1;
    wait_done(1, 400, cyc);
    chk("rp_lat1", cyc, 369);
    step(1);
    rep_v[1] = 1'b0;
    chk("rp_reopen", {flag_v[1], busy_v[1]}, 2'b01);
    chk("rp_word1", rx_last[1], wa);
    wait_done(1, 400, cyc);
    chk("rp_lat2", cyc, 369);
    step(1);
    chk("rp_word2", rx_last[1], {184{1'b1}});
    chk("rp_dcnt", done_cnt[1], 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
